// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds a display value loaded through a valid/ready handshake and presents one
// nibble per scan slot with an active-low digit select. It also does leading-zero
// blanking and whole-display blinking. New values are staged in a pending register
// and applied only on a frame boundary, so a frame never mixes old and new digits.
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    load_blz,
    input  logic                    blink_en,
    output logic [3:0]              hex_num,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    blank
);

    localparam int unsigned DataW  = 4 * NUM_DIGITS;
    localparam int unsigned DivW   = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

    // Scan and blink timing state
    logic [DivW-1:0]   div_q, div_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    // Displayed value and staged value
    logic [DataW-1:0]  disp_q, disp_d;
    logic              disp_blz_q, disp_blz_d;
    logic [DataW-1:0]  pend_q, pend_d;
    logic              pend_blz_q, pend_blz_d;
    logic              pend_full_q, pend_full_d;

    // Registered outputs
    logic [3:0]            hex_num_q, hex_num_d;
    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic                  blank_q, blank_d;

    // Decode helpers
    logic                  div_last;
    logic                  idx_last;
    logic                  frame_end;
    logic                  accept;
    logic [3:0]            cur_nibble;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  lz_blank;
    logic                  blink_blank;

    assign load_ready = ~pend_full_q;
    assign accept     = load_valid & load_ready;

    assign div_last  = (div_q == DivLast);
    assign idx_last  = (idx_q == IdxLast);
    assign frame_end = div_last & idx_last;

    // Slot timing: divider, digit index, frame counter and blink phase
    always_comb begin
        div_d         = div_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        if (div_last) begin
            div_d = '0;
            if (idx_last) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        if (frame_end) begin
            if (frame_cnt_q == FrameLast) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Load path: capture into pending, promote to display only on a frame boundary
    always_comb begin
        disp_d      = disp_q;
        disp_blz_d  = disp_blz_q;
        pend_d      = pend_q;
        pend_blz_d  = pend_blz_q;
        pend_full_d = pend_full_q;

        // accept implies pend empty, so these two branches never overlap; an accept
        // on the boundary cycle therefore waits for the following boundary
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            disp_blz_d  = pend_blz_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d      = load_data;
            pend_blz_d  = load_blz;
            pend_full_d = 1'b1;
        end
    end

    // Select the nibble of the current slot
    always_comb begin
        cur_nibble = 4'h0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nibble = disp_q[4*i +: 4];
            end
        end
    end

    // upper_zero[i] is set when digit i and every more significant digit are zero
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (disp_q[DataW-1 -: 4] == 4'h0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] & (disp_q[4*i +: 4] == 4'h0);
        end
    end

    // Blank decision: leading zero (never digit 0) or blink off-phase
    always_comb begin
        lz_blank = 1'b0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                lz_blank = disp_blz_q & upper_zero[i];
            end
        end
        blink_blank = blink_en & blink_phase_q;
    end

    // Next output values from current state; hex_num keeps the real nibble even when blanked
    always_comb begin
        hex_num_d = cur_nibble;
        blank_d   = lz_blank | blink_blank;
        sel_n_d   = '1;
        if (!blank_d) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (idx_q == IdxW'(i)) begin
                    sel_n_d[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            disp_q        <= '0;
            disp_blz_q    <= 1'b0;
            pend_q        <= '0;
            pend_blz_q    <= 1'b0;
            pend_full_q   <= 1'b0;
            hex_num_q     <= 4'h0;
            sel_n_q       <= '1;
            blank_q       <= 1'b1;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            disp_q        <= disp_d;
            disp_blz_q    <= disp_blz_d;
            pend_q        <= pend_d;
            pend_blz_q    <= pend_blz_d;
            pend_full_q   <= pend_full_d;
            hex_num_q     <= hex_num_d;
            sel_n_q       <= sel_n_d;
            blank_q       <= blank_d;
        end
    end

    assign hex_num     = hex_num_q;
    assign digit_sel_n = sel_n_q;
    assign blank       = blank_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner with a small timing configuration.
// The reference model counts clock edges since reset release and derives slot, frame
// and blink phase from that count arithmetically.
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * RD;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_data;
    logic          load_blz;
    logic          blink_en;
    logic [3:0]    hex_num;
    logic [ND-1:0] digit_sel_n;
    logic          blank;

    int n_pass;
    int n_total;

    // Reference model state
    int          m_n;
    logic [15:0] m_disp;
    logic        m_blz;
    logic [15:0] m_pend;
    logic        m_pend_blz;
    logic        m_pend_full;

    hex_display_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blz   (load_blz),
        .blink_en   (blink_en),
        .hex_num    (hex_num),
        .digit_sel_n(digit_sel_n),
        .blank      (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n         = 0;
        m_disp      = 16'h0;
        m_blz       = 1'b0;
        m_pend      = 16'h0;
        m_pend_blz  = 1'b0;
        m_pend_full = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   32'(digit_sel_n), 32'hF);
        check({tag, "_blank"}, 32'(blank),       32'h1);
        check({tag, "_ready"}, 32'(load_ready),  32'h1);
        check({tag, "_hex"},   32'(hex_num),     32'h0);
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, compare
    task automatic tick();
        int          slot;
        logic [3:0]  e_hex;
        logic        e_blank;
        logic [3:0]  e_sel;
        logic        lz;
        logic        phase;
        logic        accept;
        logic        boundary;
        logic [15:0] upper;

        slot     = (m_n / RD) % ND;
        upper    = m_disp >> (4 * slot);
        e_hex    = upper[3:0];
        lz       = m_blz && (slot > 0) && (upper == 16'h0);
        phase    = ((m_n / FRAME) / BF) % 2 == 1;
        e_blank  = lz || (blink_en && phase);
        e_sel    = e_blank ? 4'hF : ~(4'h1 << slot);
        accept   = load_valid && !m_pend_full;
        boundary = (m_n % FRAME) == FRAME - 1;

        @(posedge clk);
        if (boundary && m_pend_full) begin
            m_disp      = m_pend;
            m_blz       = m_pend_blz;
            m_pend_full = 1'b0;
        end else if (accept) begin
            m_pend      = load_data;
            m_pend_blz  = load_blz;
            m_pend_full = 1'b1;
        end
        m_n++;
        #1;
        check("hex_num", 32'(hex_num), 32'(e_hex));
        check("sel_n",   32'(digit_sel_n), 32'(e_sel));
        check("blank",   32'(blank), 32'(e_blank));
        check("ready",   32'(load_ready), 32'(!m_pend_full));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic offer(input logic [15:0] data, input logic blz);
        load_valid = 1'b1;
        load_data  = data;
        load_blz   = blz;
        tick();
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_blz   = 1'b0;
    endtask

    initial begin
        logic [15:0] rnd;
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_blz   = 1'b0;
        blink_en   = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;

        run(2 * FRAME + 3);

        // Plain value, no blanking
        offer(16'hA3F0, 1'b0);
        run(3 * FRAME);

        // Leading-zero blanking of the upper two digits
        offer(16'h0050, 1'b1);
        run(3 * FRAME);

        // All zero with blanking: only digit 0 lit
        offer(16'h0000, 1'b1);
        run(3 * FRAME);

        // Held offer while pending is full
        offer(16'h7654, 1'b0);
        load_valid = 1'b1;
        load_data  = 16'h1111;
        run(3 * FRAME);
        load_valid = 1'b0;
        run(FRAME);

        // Blinking, then disabled mid-frame
        blink_en = 1'b1;
        run(5 * FRAME + 6);
        blink_en = 1'b0;
        run(2 * FRAME);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                rnd[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            load_data = rnd;
            load_blz  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
            tick();
        end
        load_valid = 1'b0;
        blink_en   = 1'b0;
        run(2 * FRAME);

        // Asynchronous reset mid-frame with a value pending
        run(5);
        offer(16'hBEEF, 1'b1);
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_after_edges");
        model_reset();
        rst_n = 1'b1;
        run(4 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
